// File: rtl/multi_edge_pulse_gen_if.sv
// Bundle of per-channel strobe inputs and pulse/count outputs for multi_edge_pulse_gen.
interface multi_edge_pulse_gen_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
) ();
  logic [NUM_CH-1:0]       IN_DATA;
  logic [2*NUM_CH-1:0]     EDGE_SEL;
  logic [NUM_CH-1:0]       CNT_CLR;
  logic [NUM_CH-1:0]       OUT_DATA;
  logic                    OUT_ANY;
  logic [NUM_CH*CNT_W-1:0] EVENT_CNT;

  modport master (
    output IN_DATA, EDGE_SEL, CNT_CLR,
    input  OUT_DATA, OUT_ANY, EVENT_CNT
  );

  modport slave (
    input  IN_DATA, EDGE_SEL, CNT_CLR,
    output OUT_DATA, OUT_ANY, EVENT_CNT
  );
endinterface

// File: rtl/multi_edge_pulse_gen.sv
// Per-channel synchronised edge detector driving a stretchable pulse and a saturating
// event counter; channels are fully independent.
module multi_edge_pulse_gen #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PULSE_LEN   = 1,
  parameter int unsigned RETRIGGER   = 1,
  parameter int unsigned CNT_W       = 16
) (
  input logic                    CLK,
  input logic                    RESET,
  multi_edge_pulse_gen_if.slave  io_bus
);

  localparam logic [7:0] PulseLenM1 = 8'(PULSE_LEN - 1);

  logic [SYNC_STAGES:0]    r_sync [NUM_CH];
  logic [7:0]              r_pc   [NUM_CH];
  logic [CNT_W-1:0]        r_cnt  [NUM_CH];

  logic [NUM_CH-1:0]       w_rise;
  logic [NUM_CH-1:0]       w_fall;
  logic [NUM_CH-1:0]       w_edge;
  logic [NUM_CH-1:0]       w_out;
  logic [NUM_CH*CNT_W-1:0] w_cnt_flat;

  // Top of the chain is the history flop; the one below it is the current level.
  always_comb begin
    w_rise     = '0;
    w_fall     = '0;
    w_edge     = '0;
    w_out      = '0;
    w_cnt_flat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_rise[i] = r_sync[i][SYNC_STAGES-1] & ~r_sync[i][SYNC_STAGES];
      w_fall[i] = ~r_sync[i][SYNC_STAGES-1] & r_sync[i][SYNC_STAGES];
      w_edge[i] = (io_bus.EDGE_SEL[2*i] & w_rise[i]) | (io_bus.EDGE_SEL[2*i+1] & w_fall[i]);
      w_out[i]  = w_edge[i] | (r_pc[i] != 8'd0);
      w_cnt_flat[i*CNT_W +: CNT_W] = r_cnt[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_sync[i] <= '0;
        r_pc[i]   <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-1:0], io_bus.IN_DATA[i]};

        if (w_edge[i] && (r_pc[i] == 8'd0 || RETRIGGER != 0)) begin
          r_pc[i] <= PulseLenM1;
        end else if (r_pc[i] != 8'd0) begin
          r_pc[i] <= r_pc[i] - 8'd1;
        end

        // Clear beats a coincident edge; that edge is not counted.
        if (io_bus.CNT_CLR[i]) begin
          r_cnt[i] <= '0;
        end else if (w_edge[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign io_bus.OUT_DATA  = w_out;
  assign io_bus.OUT_ANY   = |w_out;
  assign io_bus.EVENT_CNT = w_cnt_flat;

endmodule

// File: tb/tb_multi_edge_pulse_gen.sv
// Four differently-parameterised instances share one directed stimulus and are checked every
// cycle against a sample-history / pulse-end-time model, plus literal expectations.
module tb_multi_edge_pulse_gen;

  // Instance configs: u0 S1/L1, u1 S2/L4/CW3, u2 S2/L4/no retrigger, u3 S2/L8.
  localparam int CfgS  [4] = '{1, 2, 2, 2};
  localparam int CfgLen[4] = '{1, 4, 4, 8};
  localparam int CfgRt [4] = '{1, 1, 0, 1};
  localparam int CfgMax[4] = '{65535, 7, 65535, 65535};

  logic       clk;
  logic       rst;
  logic [3:0] in_d;
  logic [7:0] sel;
  logic [3:0] clr;

  int checks;
  int failures;
  bit chk_en;

  multi_edge_pulse_gen_if #(.NUM_CH(4), .CNT_W(16)) if0 ();
  multi_edge_pulse_gen_if #(.NUM_CH(4), .CNT_W(3))  if1 ();
  multi_edge_pulse_gen_if #(.NUM_CH(4), .CNT_W(16)) if2 ();
  multi_edge_pulse_gen_if #(.NUM_CH(4), .CNT_W(16)) if3 ();

  assign if0.IN_DATA = in_d;  assign if0.EDGE_SEL = sel;  assign if0.CNT_CLR = clr;
  assign if1.IN_DATA = in_d;  assign if1.EDGE_SEL = sel;  assign if1.CNT_CLR = clr;
  assign if2.IN_DATA = in_d;  assign if2.EDGE_SEL = sel;  assign if2.CNT_CLR = clr;
  assign if3.IN_DATA = in_d;  assign if3.EDGE_SEL = sel;  assign if3.CNT_CLR = clr;

  multi_edge_pulse_gen #(.NUM_CH(4), .SYNC_STAGES(1), .PULSE_LEN(1), .RETRIGGER(1),
                         .CNT_W(16)) u0 (.CLK(clk), .RESET(rst), .io_bus(if0));
  multi_edge_pulse_gen #(.NUM_CH(4), .SYNC_STAGES(2), .PULSE_LEN(4), .RETRIGGER(1),
                         .CNT_W(3))  u1 (.CLK(clk), .RESET(rst), .io_bus(if1));
  multi_edge_pulse_gen #(.NUM_CH(4), .SYNC_STAGES(2), .PULSE_LEN(4), .RETRIGGER(0),
                         .CNT_W(16)) u2 (.CLK(clk), .RESET(rst), .io_bus(if2));
  multi_edge_pulse_gen #(.NUM_CH(4), .SYNC_STAGES(2), .PULSE_LEN(8), .RETRIGGER(1),
                         .CNT_W(16)) u3 (.CLK(clk), .RESET(rst), .io_bus(if3));

  logic [3:0]  d_out [4];
  logic        d_any [4];
  logic [31:0] d_cnt [4][4];

  assign d_out[0] = if0.OUT_DATA;  assign d_any[0] = if0.OUT_ANY;
  assign d_out[1] = if1.OUT_DATA;  assign d_any[1] = if1.OUT_ANY;
  assign d_out[2] = if2.OUT_DATA;  assign d_any[2] = if2.OUT_ANY;
  assign d_out[3] = if3.OUT_DATA;  assign d_any[3] = if3.OUT_ANY;

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      d_cnt[0][c] = 32'(if0.EVENT_CNT[c*16 +: 16]);
      d_cnt[1][c] = 32'(if1.EVENT_CNT[c*3 +: 3]);
      d_cnt[2][c] = 32'(if2.EVENT_CNT[c*16 +: 16]);
      d_cnt[3][c] = 32'(if3.EVENT_CNT[c*16 +: 16]);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: hist[c][k] is IN[c] sampled k posedges ago (zeroed by reset); a pulse is the
  // half-open cycle interval [trigger, end_t); counts are plain saturating integers.
  logic [4:0] hist [4];
  int         end_t[4][4];
  int         mcnt [4][4];
  int         hi   [4][4];
  int         n;

  function automatic bit m_edge(int d, int c);
    bit cur;
    bit prev;
    cur  = hist[c][CfgS[d]-1];
    prev = hist[c][CfgS[d]];
    return (sel[2*c] && cur && !prev) || (sel[2*c+1] && !cur && prev);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic model_update();
    bit e;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        e = m_edge(d, c);
        if (rst) begin
          end_t[d][c] = 0;
          mcnt[d][c]  = 0;
        end else begin
          if (e && (CfgRt[d] != 0 || n >= end_t[d][c])) end_t[d][c] = n + CfgLen[d];
          if (clr[c]) mcnt[d][c] = 0;
          else if (e && mcnt[d][c] < CfgMax[d]) mcnt[d][c]++;
        end
      end
    end
    for (int c = 0; c < 4; c++) hist[c] = rst ? 5'd0 : {hist[c][3:0], in_d[c]};
    n++;
  endtask

  task automatic compare_all();
    bit eo;
    bit exp_any;
    for (int d = 0; d < 4; d++) begin
      exp_any = 1'b0;
      for (int c = 0; c < 4; c++) begin
        eo = m_edge(d, c) || (n < end_t[d][c]);
        exp_any |= eo;
        chk($sformatf("u%0d_out%0d_cyc%0d", d, c, n), 32'(d_out[d][c]), 32'(eo));
        chk($sformatf("u%0d_cnt%0d_cyc%0d", d, c, n), d_cnt[d][c], 32'(mcnt[d][c]));
      end
      chk($sformatf("u%0d_any_cyc%0d", d, n), 32'(d_any[d]), 32'(exp_any));
    end
  endtask

  // Inputs change 1 time unit after posedge; compare on the following negedge.
  task automatic step();
    @(negedge clk);
    if (chk_en) begin
      compare_all();
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < 4; c++)
          if (d_out[d][c] === 1'b1) hi[d][c]++;
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  int hb0, hb1, hb2;
  int w;

  initial begin
    checks = 0; failures = 0; chk_en = 1'b0; n = 0;
    for (int c = 0; c < 4; c++) hist[c] = '0;
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 4; c++) begin
        end_t[d][c] = 0; mcnt[d][c] = 0; hi[d][c] = 0;
      end
    rst = 1'b1; in_d = '0; sel = '0; clr = '0;

    step();
    chk_en = 1'b1;
    steps(2);
    chk("rst_u0_out", 32'(if0.OUT_DATA), 0);
    chk("rst_u0_any", 32'(if0.OUT_ANY), 0);
    chk("rst_u0_cnt0", d_cnt[0][0], 0);
    chk("rst_u1_cnt3", d_cnt[1][3], 0);
    rst = 1'b0;
    steps(2);

    // Single rise on ch0 with rise-only select; the later fall is ignored.
    sel = 8'b00_00_00_01;
    hb0 = hi[0][0];
    in_d[0] = 1'b1;
    steps(4);
    chk("t1_u0_cnt0", d_cnt[0][0], 1);
    chk("t1_u0_hi0", 32'(hi[0][0] - hb0), 1);
    in_d[0] = 1'b0;
    steps(4);
    chk("t1_u0_cnt0_after_fall", d_cnt[0][0], 1);
    chk("t1_u0_hi0_after_fall", 32'(hi[0][0] - hb0), 1);

    // Three toggles every 10 cycles: ch0 both edges, ch1 falls only.
    clr = 4'hF; step(); clr = '0;
    sel = 8'b00_00_10_11;
    hb0 = hi[1][0]; hb1 = hi[1][1];
    for (int t = 0; t < 3; t++) begin
      in_d[1:0] = ~in_d[1:0];
      steps(10);
    end
    chk("t2_u1_cnt0", d_cnt[1][0], 3);
    chk("t2_u1_cnt1", d_cnt[1][1], 1);
    chk("t2_u1_hi0", 32'(hi[1][0] - hb0), 12);
    chk("t2_u1_hi1", 32'(hi[1][1] - hb1), 4);
    sel = '0; in_d = '0;
    steps(6);

    // Rises two cycles apart on ch2: retrigger extends, non-retrigger does not.
    sel = 8'b00_01_00_00;
    clr = 4'b0100; step(); clr = '0;
    hb1 = hi[1][2]; hb2 = hi[2][2];
    in_d[2] = 1'b1; step();
    in_d[2] = 1'b0; step();
    in_d[2] = 1'b1; steps(9);
    in_d[2] = 1'b0; steps(4);
    chk("t3_u1_hi2", 32'(hi[1][2] - hb1), 6);
    chk("t3_u2_hi2", 32'(hi[2][2] - hb2), 4);
    chk("t3_u1_cnt2", d_cnt[1][2], 2);
    chk("t3_u2_cnt2", d_cnt[2][2], 2);

    // Saturation on the 3-bit counter, clear coincident with the 10th edge, then one more.
    sel = 8'b11_00_00_00;
    clr = 4'b1000; step(); clr = '0;
    for (int t = 0; t < 9; t++) begin
      in_d[3] = ~in_d[3];
      steps(3);
    end
    chk("t4_u1_cnt3_sat", d_cnt[1][3], 7);
    chk("t4_u2_cnt3", d_cnt[2][3], 9);
    in_d[3] = ~in_d[3];
    steps(2);
    clr = 4'b1000; step(); clr = '0;
    steps(3);
    chk("t4_u1_cnt3_clr", d_cnt[1][3], 0);
    in_d[3] = ~in_d[3];
    steps(4);
    chk("t4_u1_cnt3_after", d_cnt[1][3], 1);
    sel = '0; in_d = '0;
    steps(4);

    // IN high through reset, then reset mid-pulse on the LEN=8 instance.
    sel = 8'b00_00_00_01;
    in_d = 4'b0001; rst = 1'b1;
    steps(2);
    rst = 1'b0;
    w = 1;
    while (w <= 10) begin
      step();
      if (if3.OUT_DATA[0] === 1'b1) break;
      w++;
    end
    chk("t5_u3_first_pulse_delay", 32'(w), 2);
    steps(3);
    chk("t5_u3_out0_mid", 32'(if3.OUT_DATA[0]), 1);
    chk("t5_u3_cnt0_mid", d_cnt[3][0], 1);
    rst = 1'b1;
    step();
    chk("t5_u3_out_rst", 32'(if3.OUT_DATA), 0);
    chk("t5_u3_any_rst", 32'(if3.OUT_ANY), 0);
    chk("t5_u3_cnt0_rst", d_cnt[3][0], 0);
    rst = 1'b0; in_d = '0; sel = '0;
    steps(3);

    // Same-cycle rises on all channels with sel 00/01/10/11 on ch0..ch3.
    sel = 8'b11_10_01_00;
    in_d = 4'hF;
    step();
    chk("t6_u0_out", 32'(if0.OUT_DATA), 32'h0000_000A);
    chk("t6_u0_any", 32'(if0.OUT_ANY), 1);
    step();
    chk("t6_u1_out", 32'(if1.OUT_DATA), 32'h0000_000A);
    chk("t6_u0_out_done", 32'(if0.OUT_DATA), 0);
    steps(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
